// File: rtl/shift_feeder.sv
// -----------------------------------------------------------------------------
// shift_feeder
//   Queues shift commands in a small FIFO and presents them, one beat at a
//   time, to a downstream barrel shifter. A normal command yields a single
//   beat carrying its own shift amount. A sweep command is expanded into
//   DATA_SIZE beats of the same word with the shift amount stepping from 0 up
//   to DATA_SIZE-1.
//
//   Handshake (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. A valid source holds its payload stable
//   until that edge; ready never depends combinationally on the other side's
//   valid within this block, and in_ready never looks at out_ready.
//
// Ports
//   clk           clock, all state changes on its rising edge
//   rst           synchronous reset, active low
//   in_valid      upstream command present
//   in_ready      a command can be stored this cycle
//   in_data       word to be shifted
//   in_select     shift amount (ignored for sweep commands)
//   in_sweep      expand command into a full 0..DATA_SIZE-1 sweep
//   out_valid     data_out/select_out hold a beat for the shifter
//   out_ready     shifter consumes the current beat
//   data_out      registered word for the shifter data input
//   select_out    registered shift amount for the shifter select input
//   sweep_active  current beat belongs to a sweep
//   level         commands waiting in the FIFO (output register excluded)
//   state_dbg     current FSM state (IDLE/ISSUE/SWEEP) for observation
// -----------------------------------------------------------------------------
module shift_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 4,
  localparam int SEL_W    = $clog2(DATA_SIZE),
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [SEL_W-1:0]     in_select,
  input  logic                 in_sweep,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [SEL_W-1:0]     select_out,
  output logic                 sweep_active,
  output logic [LVL_W-1:0]     level,
  output logic [1:0]           state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_SIZE + SEL_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(DATA_SIZE - 1);

  // FIFO storage: entry = {data, select, sweep}
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;

  // Output register and FSM
  logic [1:0]           state_q, state_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [SEL_W-1:0]     sel_q, sel_d;

  logic                 push;
  logic                 pop;
  logic                 accept;
  logic [ENT_W-1:0]     head;
  logic [DATA_SIZE-1:0] head_data;
  logic [SEL_W-1:0]     head_sel;
  logic                 head_sweep;

  // Full is judged on the registered level only, so a simultaneous pop
  // never opens room for a write in the same cycle.
  assign in_ready = (level_q < LVL_W'(DEPTH)) && rst;
  assign push     = in_valid && in_ready;
  assign accept   = out_valid && out_ready;

  assign head       = mem_q[rd_ptr_q];
  assign head_data  = head[ENT_W-1 -: DATA_SIZE];
  assign head_sel   = head[1 +: SEL_W];
  assign head_sweep = head[0];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) pop = 1'b1;
      end
      ST_ISSUE, ST_SWEEP: begin
        if (accept) begin
          if (state_q == ST_SWEEP && sel_q != SEL_MAX) begin
            // Mid-sweep: step the shift amount, word stays put, FIFO untouched.
            sel_d = sel_q + SEL_W'(1);
          end else if (level_q != '0) begin
            // Last beat of the command consumed: load the next one in the
            // same edge so back-to-back commands have no bubble.
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      data_d  = head_data;
      sel_d   = head_sweep ? '0 : head_sel;
      state_d = head_sweep ? ST_SWEEP : ST_ISSUE;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      sel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_select, in_sweep};
  end

  assign out_valid    = (state_q != ST_IDLE);
  assign sweep_active = (state_q == ST_SWEEP);
  assign data_out     = data_q;
  assign select_out   = sel_q;
  assign level        = level_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_shift_feeder.sv
// -----------------------------------------------------------------------------
// tb_shift_feeder
//   Self-checking bench for shift_feeder (DATA_SIZE=8, DEPTH=4). Every
//   accepted command is expanded into its expected beats ({sweep, select,
//   data}) and queued; a monitor compares each presented beat with the queue
//   head and pops it on acceptance. Directed sequences cover reset, latency,
//   full/stall, sweep expansion, mid-sweep reset and simultaneous push/pop;
//   a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_shift_feeder;

  localparam int DS = 8;
  localparam int SW = 3;
  localparam int LW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_sweep;
  logic [DS-1:0] in_data;
  logic [SW-1:0] in_select;
  logic          out_valid, out_ready, sweep_active;
  logic [DS-1:0] data_out;
  logic [SW-1:0] select_out;
  logic [LW-1:0] level;
  logic [1:0]    state_dbg;

  shift_feeder #(.DATA_SIZE(DS), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_select    (in_select),
    .in_sweep     (in_sweep),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .select_out   (select_out),
    .sweep_active (sweep_active),
    .level        (level),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DS+SW:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs are driven just after posedge, so at negedge the values
  // seen here are exactly those the next posedge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected: got 0x%0h expected none at %0t",
                   {sweep_active, select_out, data_out}, $time);
        end else begin
          check("beat", 32'({sweep_active, select_out, data_out}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (in_sweep) begin
          for (int i = 0; i < DS; i++) exp_q.push_back({1'b1, SW'(i), in_data});
        end else begin
          exp_q.push_back({1'b0, in_select, in_data});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a posedge; returns just after the posedge of the write.
  task automatic send(input logic [DS-1:0] d, input logic [SW-1:0] s, input logic sw);
    int t = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_select = s;
    in_sweep  = sw;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", 32'(t < 200), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((out_valid || level != '0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_idle", 32'({out_valid, level}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv, ns;
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hAA; in_select = 3'd2;
    in_sweep = 1'b0; out_ready = 1'b1;

    // Reset with a write offered: nothing may be stored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_select", 32'(select_out), 32'd0);
    check("rst_sweep", 32'(sweep_active), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_idle", 32'({out_valid, level}), 32'd0);

    // Single command: one-cycle latency, then back to idle.
    @(posedge clk); #1;
    send(8'b0001_1001, 3'b001, 1'b0);
    @(negedge clk);
    check("latency_gap", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_present", 32'(out_valid), 32'd1);
    check("single_data", 32'(data_out), 32'h19);
    check("single_select", 32'(select_out), 32'd1);
    @(negedge clk);
    check("single_done", 32'({out_valid, level}), 32'd0);

    // Fill while stalled, then drain with no gaps.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h97, 3'd0, 1'b0);
    send(8'hB1, 3'd1, 1'b0);
    send(8'h85, 3'd2, 1'b0);
    send(8'h90, 3'd3, 1'b0);
    send(8'h19, 3'd4, 1'b0);
    fork
      send(8'h22, 3'd5, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", 32'(data_out), 32'h97);
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("no_gap", 32'(out_valid), 32'd1);
        end
      end
    join
    wait_idle();

    // Sweep then a normal command.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h85, 3'd6, 1'b1);
    send(8'h90, 3'd5, 1'b0);
    out_ready = 1'b1;
    nv = 0; ns = 0;
    @(negedge clk);
    while (out_valid && nv < 50) begin
      nv++;
      if (sweep_active) ns++;
      @(negedge clk);
    end
    check("sweep_total_beats", 32'(nv), 32'd9);
    check("sweep_beats", 32'(ns), 32'd8);

    // Reset in the middle of a sweep with two commands queued.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h85, 3'd0, 1'b1);
    send(8'h3C, 3'd2, 1'b0);
    send(8'h5A, 3'd4, 1'b0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("mid_sweep_select", 32'(select_out), 32'd3);
    check("mid_sweep_level", 32'(level), 32'd2);
    check("mid_sweep_active", 32'(sweep_active), 32'd1);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("flush_state", 32'({out_valid, sweep_active, level}), 32'd0);
    @(negedge clk);
    check("flush_no_beats", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(8'h77, 3'd6, 1'b0);
    @(negedge clk);
    check("after_rst_gap", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("after_rst_present", 32'({out_valid, data_out, select_out}), 32'({1'b1, 8'h77, 3'd6}));
    wait_idle();

    // Simultaneous write and accept with level 2.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h11, 3'd1, 1'b0);
    send(8'h22, 3'd2, 1'b0);
    send(8'h33, 3'd3, 1'b0);
    in_valid = 1'b1; in_data = 8'h44; in_select = 3'd4; in_sweep = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("pushpop_in_ready", 32'(in_ready), 32'd1);
    check("pushpop_level_before", 32'(level), 32'd2);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("pushpop_level_after", 32'(level), 32'd2);
    check("pushpop_next", 32'({out_valid, data_out, select_out}), 32'({1'b1, 8'h22, 3'd2}));
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = DS'($urandom);
      in_select = SW'($urandom_range(0, DS - 1));
      in_sweep  = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
